// File: rtl/abc_scan_sequencer_pkg.sv
// rtl/abc_scan_sequencer_pkg.sv - shared types and constants for the A/B/C scan sequencer
package abc_scan_sequencer_pkg;

  localparam int CODE_W = 3;

  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PP   = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam code_t CODE_MIN = '0;
  localparam code_t CODE_MAX = '1;

endpackage

// File: rtl/abc_scan_sequencer_if.sv
// rtl/abc_scan_sequencer_if.sv - control inputs and decoder select/status outputs of the sequencer
interface abc_scan_sequencer_if;
  import abc_scan_sequencer_pkg::*;

  logic  en;
  mode_e mode;
  logic  load;
  code_t load_code;
  logic  A;
  logic  B;
  logic  C;
  logic  step;
  logic  wrap;
  logic  dir;

  modport master (
    output en, mode, load, load_code,
    input  A, B, C, step, wrap, dir
  );

  modport slave (
    input  en, mode, load, load_code,
    output A, B, C, step, wrap, dir
  );

endinterface

// File: rtl/abc_scan_sequencer_scan_tick_divider.sv
// rtl/abc_scan_sequencer_scan_tick_divider.sv - prescaler producing one tick every DIV enabled cycles
module scan_tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // en=0 freezes the count in place so a paused scan resumes mid-step
  assign o_tick = i_en && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/abc_scan_sequencer.sv
// rtl/abc_scan_sequencer.sv - steps a 3-bit {A,B,C} code up/down/ping-pong for a 3-to-8 decoder
module abc_scan_sequencer
  import abc_scan_sequencer_pkg::*;
#(
  parameter int    DIV        = 4,
  parameter code_t START_CODE = 3'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  abc_scan_sequencer_if.slave  bus
);

  logic  w_tick;
  code_t r_code;
  code_t w_code_nxt;
  dir_e  r_dir;
  dir_e  w_dir_nxt;
  logic  r_step;
  logic  r_wrap;
  logic  w_step_nxt;
  logic  w_wrap_nxt;

  scan_tick_divider #(
    .DIV (DIV)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .i_en   (bus.en),
    .i_clr  (bus.load),
    .o_tick (w_tick)
  );

  always_comb begin
    w_code_nxt = r_code;
    w_dir_nxt  = r_dir;
    w_step_nxt = 1'b0;
    w_wrap_nxt = 1'b0;
    if (bus.load) begin
      w_code_nxt = bus.load_code;
      w_dir_nxt  = DIR_UP;
    end else if (w_tick) begin
      case (bus.mode)
        MODE_UP: begin
          w_code_nxt = r_code + 1'b1;
          w_dir_nxt  = DIR_UP;
          w_step_nxt = 1'b1;
          w_wrap_nxt = (r_code == CODE_MAX);
        end
        MODE_DOWN: begin
          w_code_nxt = r_code - 1'b1;
          w_dir_nxt  = DIR_DOWN;
          w_step_nxt = 1'b1;
          w_wrap_nxt = (r_code == CODE_MIN);
        end
        MODE_PP: begin
          w_step_nxt = 1'b1;
          // direction flips on arriving at an end; the frame closes on arrival at 0
          if (r_dir == DIR_UP) begin
            if (r_code == CODE_MAX) begin
              w_code_nxt = CODE_MAX - 1'b1;
              w_dir_nxt  = DIR_DOWN;
            end else begin
              w_code_nxt = r_code + 1'b1;
              if (r_code == CODE_MAX - 1'b1) w_dir_nxt = DIR_DOWN;
            end
          end else begin
            if (r_code == CODE_MIN) begin
              w_code_nxt = CODE_MIN + 1'b1;
              w_dir_nxt  = DIR_UP;
              w_wrap_nxt = 1'b1;
            end else begin
              w_code_nxt = r_code - 1'b1;
              if (r_code == CODE_MIN + 1'b1) begin
                w_dir_nxt  = DIR_UP;
                w_wrap_nxt = 1'b1;
              end
            end
          end
        end
        MODE_HOLD: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code <= START_CODE;
      r_dir  <= DIR_UP;
      r_step <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_code <= w_code_nxt;
      r_dir  <= w_dir_nxt;
      r_step <= w_step_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign bus.A    = r_code[2];
  assign bus.B    = r_code[1];
  assign bus.C    = r_code[0];
  assign bus.step = r_step;
  assign bus.wrap = r_wrap;
  assign bus.dir  = r_dir;

endmodule
